// File: rtl/morse_char_rx_buffer.sv
// 8N1 serial receiver feeding a 26-slot, two-row text buffer with cursor, backspace, newline and scroll.
// Optional MORSE_RX_UPCASE_EN folds lowercase letters to uppercase before storing.
//
// state  | meaning
// IDLE   | line idle, waiting for a low level on rxs
// START  | timing to mid start bit, rejecting glitches
// DATA   | sampling 8 data bits, LSB first, one per bit time
// STOP   | timing to mid stop bit, checking framing
// COMMIT | applying the received byte to the buffer
module morse_char_rx_buffer #(
    parameter int         CLKS_PER_BIT = 938,
    parameter int         NUM_CHARS    = 26,
    parameter int         ROW_LEN      = 13,
    parameter logic [7:0] BLANK        = 8'h20
) (
    input  logic                   cclk,
    input  logic                   rstb,
    input  logic                   inputCharBit,
    output logic [8*NUM_CHARS-1:0] chars,
    output logic [4:0]             cursor,
    output logic                   byte_stb,
    output logic                   frame_err
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_COMMIT} state_t;

    localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
    localparam logic [4:0]  FULL     = 5'(NUM_CHARS);
    localparam logic [4:0]  ROW2     = 5'(ROW_LEN);

    state_t      r_state, w_next_state;
    logic [1:0]  r_sync;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic [4:0]  r_cursor;
    logic        r_byte_stb, r_frame_err;
    logic [7:0]  r_chars [NUM_CHARS];

    logic        w_rxs, w_cnt_clr, w_shift_en, w_ferr, w_printable;
    logic [7:0]  w_byte;

    assign w_rxs = r_sync[1];

`ifdef MORSE_RX_UPCASE_EN
    assign w_byte = (r_shift >= 8'h61 && r_shift <= 8'h7A) ? (r_shift - 8'h20) : r_shift;
`else
    assign w_byte = r_shift;
`endif

    assign w_printable = (w_byte >= 8'h20) && (w_byte <= 8'h7E);

    always_ff @(posedge cclk) begin
        if (!rstb) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_shift_en   = 1'b0;
        w_ferr       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!w_rxs) w_next_state = S_START;
            end
            S_START: begin
                if (r_cnt == HALF_END) begin
                    w_cnt_clr    = 1'b1;
                    w_next_state = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_clr = 1'b1;
                    if (w_rxs) begin
                        w_next_state = S_COMMIT;
                    end else begin
                        w_ferr       = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_COMMIT: begin
                w_cnt_clr    = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge cclk) begin
        if (!rstb) begin
            r_sync      <= 2'b11;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_cursor    <= '0;
            r_byte_stb  <= 1'b0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < NUM_CHARS; i++) r_chars[i] <= BLANK;
        end else begin
            r_sync      <= {r_sync[0], inputCharBit};
            r_cnt       <= w_cnt_clr ? 16'd0 : r_cnt + 16'd1;
            r_byte_stb  <= 1'b0;
            r_frame_err <= w_ferr;
            if (r_state == S_START) r_bit_idx <= '0;
            if (w_shift_en) begin
                r_shift   <= {w_rxs, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (r_state == S_COMMIT) begin
                r_byte_stb <= 1'b1;
                if (w_printable) begin
                    if (r_cursor < FULL) begin
                        r_chars[r_cursor] <= w_byte;
                        r_cursor          <= r_cursor + 5'd1;
                    end else begin
                        // Scroll row 2 up, then the new byte opens row 2 (later NBA wins).
                        for (int i = 0; i < ROW_LEN; i++) r_chars[i] <= r_chars[i+ROW_LEN];
                        for (int i = ROW_LEN; i < NUM_CHARS; i++) r_chars[i] <= BLANK;
                        r_chars[ROW_LEN] <= w_byte;
                        r_cursor         <= ROW2 + 5'd1;
                    end
                end else if (w_byte == 8'h08) begin
                    if (r_cursor != 5'd0) begin
                        r_chars[r_cursor-5'd1] <= BLANK;
                        r_cursor               <= r_cursor - 5'd1;
                    end
                end else if (w_byte == 8'h0A || w_byte == 8'h0D) begin
                    if (r_cursor >= ROW2) begin
                        for (int i = 0; i < ROW_LEN; i++) r_chars[i] <= r_chars[i+ROW_LEN];
                        for (int i = ROW_LEN; i < NUM_CHARS; i++) r_chars[i] <= BLANK;
                    end
                    r_cursor <= ROW2;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CHARS; g++) begin : g_flat
        assign chars[8*g+:8] = r_chars[g];
    end

    assign cursor    = r_cursor;
    assign byte_stb  = r_byte_stb;
    assign frame_err = r_frame_err;

endmodule
